// File: rtl/bridge_uart_arbiter.sv
// Two-requester arbiter in front of a single UART bridge port.
// Grants one requester at a time (round-robin on contention), latches its
// request onto the bridge, and relays the 4-phase handshake back to it.
// A cycle budget in ACTIVE aborts a transaction that is never acknowledged.
module bridge_uart_arbiter #(
   parameter int ADDR_WIDTH     = 6,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  m0_read,
   input  logic                  m0_write,
   input  logic [3:0]            m0_byte_enable,
   input  logic [ADDR_WIDTH-1:0] m0_address,
   input  logic [DATA_WIDTH-1:0] m0_write_data,
   output logic [DATA_WIDTH-1:0] m0_read_data,
   output logic                  m0_acknowledge,
   input  logic                  m1_read,
   input  logic                  m1_write,
   input  logic [3:0]            m1_byte_enable,
   input  logic [ADDR_WIDTH-1:0] m1_address,
   input  logic [DATA_WIDTH-1:0] m1_write_data,
   output logic [DATA_WIDTH-1:0] m1_read_data,
   output logic                  m1_acknowledge,
   output logic                  bridge_uart_read,
   output logic                  bridge_uart_write,
   output logic [3:0]            bridge_uart_byte_enable,
   output logic [ADDR_WIDTH-1:0] bridge_uart_address,
   output logic [DATA_WIDTH-1:0] bridge_uart_write_data,
   input  logic                  bridge_uart_acknowledge,
   input  logic [DATA_WIDTH-1:0] bridge_uart_read_data,
   output logic [1:0]            grant,
   output logic                  timeout_error
);

   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACTIVE = 2'd1,
      ST_HOLD   = 2'd2,
      ST_DRAIN  = 2'd3
   } state_t;

   state_t                state_q, state_d;
   logic [1:0]            grant_q, grant_d;
   logic                  owner_q, owner_d;
   logic                  rr_q, rr_d;
   logic                  bus_read_q, bus_read_d;
   logic                  bus_write_q, bus_write_d;
   logic [3:0]            be_q, be_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [DATA_WIDTH-1:0] rdata0_q, rdata0_d;
   logic [DATA_WIDTH-1:0] rdata1_q, rdata1_d;
   logic                  ack0_q, ack0_d;
   logic                  ack1_q, ack1_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic                  tmo_q, tmo_d;

   logic pend0_s, pend1_s, sel_s, owner_pend_s;

   // Pending flags and arbitration choice (rr_q breaks ties).
   always_comb begin
      pend0_s = m0_read | m0_write;
      pend1_s = m1_read | m1_write;
      if (pend0_s && pend1_s) begin
         sel_s = rr_q;
      end else begin
         sel_s = pend1_s;
      end
      if (owner_q) begin
         owner_pend_s = pend1_s;
      end else begin
         owner_pend_s = pend0_s;
      end
   end

   // Next-state and next-output computation for the handshake FSM.
   always_comb begin
      state_d     = state_q;
      grant_d     = grant_q;
      owner_d     = owner_q;
      rr_d        = rr_q;
      bus_read_d  = bus_read_q;
      bus_write_d = bus_write_q;
      be_d        = be_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      rdata0_d    = rdata0_q;
      rdata1_d    = rdata1_q;
      ack0_d      = ack0_q;
      ack1_d      = ack1_q;
      cnt_d       = cnt_q;
      tmo_d       = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (pend0_s || pend1_s) begin
               owner_d = sel_s;
               cnt_d   = '0;
               state_d = ST_ACTIVE;
               if (sel_s) begin
                  grant_d     = 2'b10;
                  bus_write_d = m1_write;
                  bus_read_d  = m1_read & ~m1_write;
                  be_d        = m1_byte_enable;
                  addr_d      = m1_address;
                  wdata_d     = m1_write_data;
               end else begin
                  grant_d     = 2'b01;
                  bus_write_d = m0_write;
                  bus_read_d  = m0_read & ~m0_write;
                  be_d        = m0_byte_enable;
                  addr_d      = m0_address;
                  wdata_d     = m0_write_data;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_ACTIVE: begin
            if (bridge_uart_acknowledge) begin
               state_d = ST_HOLD;
               if (owner_q) begin
                  ack1_d = 1'b1;
                  if (bus_read_q) begin
                     rdata1_d = bridge_uart_read_data;
                  end else begin
                     rdata1_d = rdata1_q;
                  end
               end else begin
                  ack0_d = 1'b1;
                  if (bus_read_q) begin
                     rdata0_d = bridge_uart_read_data;
                  end else begin
                     rdata0_d = rdata0_q;
                  end
               end
            end else if (cnt_q == CNT_LAST) begin
               // Abort: drop the bridge request and complete with all ones.
               state_d     = ST_HOLD;
               bus_read_d  = 1'b0;
               bus_write_d = 1'b0;
               tmo_d       = 1'b1;
               if (owner_q) begin
                  ack1_d   = 1'b1;
                  rdata1_d = '1;
               end else begin
                  ack0_d   = 1'b1;
                  rdata0_d = '1;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_HOLD: begin
            if (!owner_pend_s) begin
               bus_read_d  = 1'b0;
               bus_write_d = 1'b0;
               ack0_d      = 1'b0;
               ack1_d      = 1'b0;
               state_d     = ST_DRAIN;
            end else begin
               state_d = ST_HOLD;
            end
         end
         ST_DRAIN: begin
            if (!bridge_uart_acknowledge) begin
               grant_d = 2'b00;
               rr_d    = ~owner_q;
               state_d = ST_IDLE;
            end else begin
               state_d = ST_DRAIN;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and output registers; async reset clears everything at once.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         grant_q     <= 2'b00;
         owner_q     <= 1'b0;
         rr_q        <= 1'b0;
         bus_read_q  <= 1'b0;
         bus_write_q <= 1'b0;
         be_q        <= 4'h0;
         addr_q      <= '0;
         wdata_q     <= '0;
         rdata0_q    <= '0;
         rdata1_q    <= '0;
         ack0_q      <= 1'b0;
         ack1_q      <= 1'b0;
         cnt_q       <= '0;
         tmo_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         grant_q     <= grant_d;
         owner_q     <= owner_d;
         rr_q        <= rr_d;
         bus_read_q  <= bus_read_d;
         bus_write_q <= bus_write_d;
         be_q        <= be_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         rdata0_q    <= rdata0_d;
         rdata1_q    <= rdata1_d;
         ack0_q      <= ack0_d;
         ack1_q      <= ack1_d;
         cnt_q       <= cnt_d;
         tmo_q       <= tmo_d;
      end
   end

   assign m0_read_data            = rdata0_q;
   assign m1_read_data            = rdata1_q;
   assign m0_acknowledge          = ack0_q;
   assign m1_acknowledge          = ack1_q;
   assign bridge_uart_read        = bus_read_q;
   assign bridge_uart_write       = bus_write_q;
   assign bridge_uart_byte_enable = be_q;
   assign bridge_uart_address     = addr_q;
   assign bridge_uart_write_data  = wdata_q;
   assign grant                   = grant_q;
   assign timeout_error           = tmo_q;

endmodule

// File: tb/tb_bridge_uart_arbiter.sv
// Directed bench for bridge_uart_arbiter: a vector table of single-requester
// transactions plus hand-written arbitration, timeout, latching and reset cases.
module tb_bridge_uart_arbiter;

   logic        clock = 1'b0;
   logic        reset;
   logic        m0_read, m0_write, m1_read, m1_write;
   logic [3:0]  m0_byte_enable, m1_byte_enable;
   logic [5:0]  m0_address, m1_address;
   logic [31:0] m0_write_data, m1_write_data;
   logic [31:0] m0_read_data, m1_read_data;
   logic        m0_acknowledge, m1_acknowledge;
   logic        bridge_uart_read, bridge_uart_write;
   logic [3:0]  bridge_uart_byte_enable;
   logic [5:0]  bridge_uart_address;
   logic [31:0] bridge_uart_write_data;
   logic        bridge_uart_acknowledge;
   logic [31:0] bridge_uart_read_data;
   logic [1:0]  grant;
   logic        timeout_error;

   int checks = 0;
   int errors = 0;

   bridge_uart_arbiter #(
      .ADDR_WIDTH(6), .DATA_WIDTH(32), .TIMEOUT_CYCLES(16)
   ) dut (
      .clock(clock), .reset(reset),
      .m0_read(m0_read), .m0_write(m0_write), .m0_byte_enable(m0_byte_enable),
      .m0_address(m0_address), .m0_write_data(m0_write_data),
      .m0_read_data(m0_read_data), .m0_acknowledge(m0_acknowledge),
      .m1_read(m1_read), .m1_write(m1_write), .m1_byte_enable(m1_byte_enable),
      .m1_address(m1_address), .m1_write_data(m1_write_data),
      .m1_read_data(m1_read_data), .m1_acknowledge(m1_acknowledge),
      .bridge_uart_read(bridge_uart_read), .bridge_uart_write(bridge_uart_write),
      .bridge_uart_byte_enable(bridge_uart_byte_enable),
      .bridge_uart_address(bridge_uart_address),
      .bridge_uart_write_data(bridge_uart_write_data),
      .bridge_uart_acknowledge(bridge_uart_acknowledge),
      .bridge_uart_read_data(bridge_uart_read_data),
      .grant(grant), .timeout_error(timeout_error)
   );

   always #5 clock = ~clock;

   typedef struct {
      int          m;
      logic        rd;
      logic        wr;
      logic [5:0]  addr;
      logic [31:0] wdata;
      logic [3:0]  be;
      logic [31:0] brdata;
      logic        exp_br;
      logic        exp_bw;
      logic [31:0] exp_rdata;
      logic [31:0] exp_other;
   } vec_t;

   vec_t vecs[8];

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic set_req(input int m, input logic rd, input logic wr, input logic [5:0] a,
                          input logic [31:0] wd, input logic [3:0] be);
      if (m == 0) begin
         m0_read = rd; m0_write = wr; m0_address = a; m0_write_data = wd; m0_byte_enable = be;
      end else begin
         m1_read = rd; m1_write = wr; m1_address = a; m1_write_data = wd; m1_byte_enable = be;
      end
   endtask

   function automatic logic ack_of(input int m);
      return (m == 0) ? m0_acknowledge : m1_acknowledge;
   endfunction

   function automatic logic [31:0] rdata_of(input int m);
      return (m == 0) ? m0_read_data : m1_read_data;
   endfunction

   // Bridge acks, requester m drops its request, bridge drops ack.
   task automatic finish_txn(input int m, input logic [31:0] brdata);
      bridge_uart_acknowledge = 1'b1;
      bridge_uart_read_data   = brdata;
      tick();
      set_req(m, 1'b0, 1'b0, 6'h00, 32'h0, 4'h0);
      tick();
      bridge_uart_acknowledge = 1'b0;
      tick();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      repeat (2) @(posedge clock);
      @(negedge clock);
      reset = 1'b0;
      #1;
   endtask

   initial begin
      vecs[0] = '{0, 1'b1, 1'b0, 6'h00, 32'h0,        4'hF, 32'h168,      1'b1, 1'b0, 32'h168,      32'h0};
      vecs[1] = '{0, 1'b1, 1'b0, 6'h01, 32'h0,        4'h1, 32'h67,       1'b1, 1'b0, 32'h67,       32'h0};
      vecs[2] = '{0, 1'b1, 1'b0, 6'h02, 32'h0,        4'h1, 32'h75,       1'b1, 1'b0, 32'h75,       32'h0};
      vecs[3] = '{0, 1'b1, 1'b0, 6'h03, 32'h0,        4'h1, 32'h69,       1'b1, 1'b0, 32'h69,       32'h0};
      vecs[4] = '{0, 1'b1, 1'b0, 6'h04, 32'h0,        4'h1, 32'h0A,       1'b1, 1'b0, 32'h0A,       32'h0};
      vecs[5] = '{1, 1'b0, 1'b1, 6'h3F, 32'hDEADBEEF, 4'h3, 32'h12345678, 1'b0, 1'b1, 32'h0,        32'h0A};
      vecs[6] = '{1, 1'b1, 1'b0, 6'h10, 32'h0,        4'hF, 32'hCAFEF00D, 1'b1, 1'b0, 32'hCAFEF00D, 32'h0A};
      vecs[7] = '{0, 1'b1, 1'b1, 6'h22, 32'h55AA55AA, 4'hC, 32'h99999999, 1'b0, 1'b1, 32'h0A,       32'hCAFEF00D};

      reset = 1'b1;
      set_req(0, 1'b0, 1'b0, 6'h00, 32'h0, 4'h0);
      set_req(1, 1'b0, 1'b0, 6'h00, 32'h0, 4'h0);
      bridge_uart_acknowledge = 1'b0;
      bridge_uart_read_data   = 32'h0;
      do_reset();

      chk("reset_grant", {30'd0, grant}, 32'h0);
      chk("reset_br", {31'd0, bridge_uart_read}, 32'h0);
      chk("reset_bw", {31'd0, bridge_uart_write}, 32'h0);
      chk("reset_ack", {30'd0, m1_acknowledge, m0_acknowledge}, 32'h0);
      chk("reset_rdata0", m0_read_data, 32'h0);
      chk("reset_tmo", {31'd0, timeout_error}, 32'h0);

      // Table of single-requester transactions.
      for (int i = 0; i < 8; i++) begin
         set_req(vecs[i].m, vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].be);
         tick();
         chk($sformatf("v%0d_grant", i), {30'd0, grant}, (vecs[i].m == 1) ? 32'h2 : 32'h1);
         chk($sformatf("v%0d_br", i), {31'd0, bridge_uart_read}, {31'd0, vecs[i].exp_br});
         chk($sformatf("v%0d_bw", i), {31'd0, bridge_uart_write}, {31'd0, vecs[i].exp_bw});
         chk($sformatf("v%0d_addr", i), {26'd0, bridge_uart_address}, {26'd0, vecs[i].addr});
         chk($sformatf("v%0d_be", i), {28'd0, bridge_uart_byte_enable}, {28'd0, vecs[i].be});
         chk($sformatf("v%0d_wdata", i), bridge_uart_write_data, vecs[i].wdata);
         bridge_uart_acknowledge = 1'b1;
         bridge_uart_read_data   = vecs[i].brdata;
         tick();
         chk($sformatf("v%0d_ack", i), {31'd0, ack_of(vecs[i].m)}, 32'h1);
         chk($sformatf("v%0d_other_ack", i), {31'd0, ack_of(1 - vecs[i].m)}, 32'h0);
         chk($sformatf("v%0d_rdata", i), rdata_of(vecs[i].m), vecs[i].exp_rdata);
         chk($sformatf("v%0d_other_rdata", i), rdata_of(1 - vecs[i].m), vecs[i].exp_other);
         set_req(vecs[i].m, 1'b0, 1'b0, 6'h00, 32'h0, 4'h0);
         tick();
         chk($sformatf("v%0d_drop_req", i), {30'd0, bridge_uart_write, bridge_uart_read}, 32'h0);
         chk($sformatf("v%0d_drop_ack", i), {31'd0, ack_of(vecs[i].m)}, 32'h0);
         chk($sformatf("v%0d_drain_grant", i), {30'd0, grant}, (vecs[i].m == 1) ? 32'h2 : 32'h1);
         bridge_uart_acknowledge = 1'b0;
         tick();
         chk($sformatf("v%0d_idle_grant", i), {30'd0, grant}, 32'h0);
      end

      // Round-robin: simultaneous requests after reset favour m0.
      do_reset();
      set_req(0, 1'b0, 1'b1, 6'h11, 32'h1, 4'hF);
      set_req(1, 1'b1, 1'b0, 6'h22, 32'h0, 4'hF);
      tick();
      chk("rr1_grant", {30'd0, grant}, 32'h1);
      chk("rr1_bw", {31'd0, bridge_uart_write}, 32'h1);
      chk("rr1_addr", {26'd0, bridge_uart_address}, 32'h11);
      finish_txn(0, 32'h0);
      chk("rr1_idle_gap", {30'd0, grant}, 32'h0);
      tick();
      chk("rr2_grant", {30'd0, grant}, 32'h2);
      chk("rr2_addr", {26'd0, bridge_uart_address}, 32'h22);
      chk("rr2_m0_ack", {31'd0, m0_acknowledge}, 32'h0);
      bridge_uart_acknowledge = 1'b1;
      bridge_uart_read_data   = 32'h77;
      tick();
      chk("rr2_rdata", m1_read_data, 32'h77);
      set_req(0, 1'b1, 1'b0, 6'h01, 32'h0, 4'hF);
      set_req(1, 1'b0, 1'b0, 6'h00, 32'h0, 4'h0);
      tick();
      bridge_uart_acknowledge = 1'b0;
      set_req(1, 1'b1, 1'b0, 6'h02, 32'h0, 4'hF);
      tick();
      tick();
      chk("rr3_grant", {30'd0, grant}, 32'h1);
      finish_txn(0, 32'h5);
      tick();
      chk("rr4_grant", {30'd0, grant}, 32'h2);
      finish_txn(1, 32'h6);

      // Timeout: m1 read never acknowledged.
      set_req(1, 1'b1, 1'b0, 6'h07, 32'h0, 4'hF);
      tick();
      chk("tmo_grant", {30'd0, grant}, 32'h2);
      for (int c = 1; c < 16; c++) begin
         tick();
         chk($sformatf("tmo_wait%0d", c), {30'd0, timeout_error, ~bridge_uart_read}, 32'h0);
      end
      tick();
      chk("tmo_pulse", {31'd0, timeout_error}, 32'h1);
      chk("tmo_rdata", m1_read_data, 32'hFFFFFFFF);
      chk("tmo_ack", {31'd0, m1_acknowledge}, 32'h1);
      chk("tmo_br", {31'd0, bridge_uart_read}, 32'h0);
      chk("tmo_m0_rdata", m0_read_data, 32'h5);
      tick();
      chk("tmo_pulse_end", {31'd0, timeout_error}, 32'h0);
      chk("tmo_ack_hold", {31'd0, m1_acknowledge}, 32'h1);
      set_req(1, 1'b0, 1'b0, 6'h00, 32'h0, 4'h0);
      tick();
      chk("tmo_ack_drop", {31'd0, m1_acknowledge}, 32'h0);
      tick();
      chk("tmo_idle", {30'd0, grant}, 32'h0);

      // Latched address holds; withdrawal in ACTIVE is ignored.
      set_req(0, 1'b1, 1'b0, 6'h05, 32'h0, 4'hF);
      tick();
      set_req(0, 1'b1, 1'b0, 6'h3F, 32'hFFFF0000, 4'h0);
      tick();
      chk("latch_addr", {26'd0, bridge_uart_address}, 32'h05);
      chk("latch_be", {28'd0, bridge_uart_byte_enable}, 32'hF);
      set_req(0, 1'b0, 1'b0, 6'h3F, 32'h0, 4'h0);
      tick();
      chk("withdraw_br", {31'd0, bridge_uart_read}, 32'h1);
      chk("withdraw_grant", {30'd0, grant}, 32'h1);
      chk("withdraw_noack", {31'd0, m0_acknowledge}, 32'h0);
      bridge_uart_acknowledge = 1'b1;
      bridge_uart_read_data   = 32'h0BADC0DE;
      tick();
      chk("withdraw_ack", {31'd0, m0_acknowledge}, 32'h1);
      chk("withdraw_rdata", m0_read_data, 32'h0BADC0DE);
      tick();
      chk("withdraw_ack_drop", {31'd0, m0_acknowledge}, 32'h0);
      bridge_uart_acknowledge = 1'b0;
      tick();
      chk("withdraw_idle", {30'd0, grant}, 32'h0);

      // Reset asserted in HOLD, then m1 alone is granted normally.
      set_req(0, 1'b1, 1'b0, 6'h0C, 32'h0, 4'hF);
      tick();
      bridge_uart_acknowledge = 1'b1;
      bridge_uart_read_data   = 32'h11;
      tick();
      chk("hold_ack", {31'd0, m0_acknowledge}, 32'h1);
      set_req(1, 1'b1, 1'b0, 6'h09, 32'h0, 4'hF);
      #2;
      reset = 1'b1;
      #1;
      chk("rst_grant", {30'd0, grant}, 32'h0);
      chk("rst_ack", {31'd0, m0_acknowledge}, 32'h0);
      chk("rst_rdata0", m0_read_data, 32'h0);
      chk("rst_br", {31'd0, bridge_uart_read}, 32'h0);
      chk("rst_addr", {26'd0, bridge_uart_address}, 32'h0);
      set_req(0, 1'b0, 1'b0, 6'h00, 32'h0, 4'h0);
      bridge_uart_acknowledge = 1'b0;
      @(negedge clock);
      reset = 1'b0;
      tick();
      chk("post_rst_grant", {30'd0, grant}, 32'h2);
      chk("post_rst_addr", {26'd0, bridge_uart_address}, 32'h09);
      chk("post_rst_m0_ack", {31'd0, m0_acknowledge}, 32'h0);
      bridge_uart_acknowledge = 1'b1;
      bridge_uart_read_data   = 32'h3C;
      tick();
      chk("post_rst_rdata", m1_read_data, 32'h3C);
      chk("post_rst_ack", {31'd0, m1_acknowledge}, 32'h1);
      set_req(1, 1'b0, 1'b0, 6'h00, 32'h0, 4'h0);
      tick();
      bridge_uart_acknowledge = 1'b0;
      tick();
      chk("post_rst_idle", {30'd0, grant}, 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/bridge_uart_arbiter.md
BRIDGE_UART_ARBITER -- requirements
Module: bridge_uart_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 6, address width of all ports.
REQ-002 Parameter DATA_WIDTH, default 32, data width of all ports.
REQ-003 Parameter TIMEOUT_CYCLES, default 1024, maximum cycles waiting for bridge acknowledge before abort.
REQ-004 clock  input  1  single clock; all logic on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 mN_read, mN_write (N=0,1)  input  1 each  requester N read/write request, 4-phase level handshake.
REQ-007 mN_byte_enable  input  4  requester N byte enables.
REQ-008 mN_address  input  ADDR_WIDTH  requester N address.
REQ-009 mN_write_data  input  DATA_WIDTH  requester N write data.
REQ-010 mN_read_data  output  DATA_WIDTH  read data returned to requester N.
REQ-011 mN_acknowledge  output  1  acknowledge to requester N.
REQ-012 bridge_uart_read, bridge_uart_write  output  1 each  forwarded request to UART bridge.
REQ-013 bridge_uart_byte_enable  output  4; bridge_uart_address  output  ADDR_WIDTH; bridge_uart_write_data  output  DATA_WIDTH.
REQ-014 bridge_uart_acknowledge  input  1; bridge_uart_read_data  input  DATA_WIDTH.
REQ-015 grant  output  2  one-hot owner (bit N = requester N), 0 when idle.
REQ-016 timeout_error  output  1  one-cycle pulse on transaction abort.

Function
REQ-017 Requester N pending = mN_read OR mN_write; simultaneous read and write from one requester SHALL be treated as write.
REQ-018 FSM states IDLE, ACTIVE, HOLD, DRAIN; all outputs SHALL be registered.
REQ-019 IDLE: if any pending, grant SHALL go to the pending requester; if both pending, to the requester not served last (round-robin pointer, reset value 0 = requester 0 preferred); next state ACTIVE.
REQ-020 Entry to ACTIVE: address, byte_enable, write_data and read/write type of the granted requester SHALL be latched and driven on bridge_uart_* the same cycle grant asserts (one cycle after the request is sampled).
REQ-021 ACTIVE: on bridge_uart_acknowledge=1, latch bridge_uart_read_data into mN_read_data (reads only), assert mN_acknowledge next cycle, go HOLD.
REQ-022 HOLD: when granted requester deasserts its request, bridge_uart_read/write and mN_acknowledge SHALL deassert next cycle; go DRAIN.
REQ-023 DRAIN: when bridge_uart_acknowledge=0, clear grant, toggle round-robin pointer to favour the other requester, go IDLE; a new grant SHALL occur no earlier than the following cycle.
REQ-024 Non-granted requester SHALL see mN_acknowledge=0 and unchanged mN_read_data throughout.
REQ-025 Timeout counter SHALL count cycles in ACTIVE; at TIMEOUT_CYCLES without acknowledge: deassert bridge request, pulse timeout_error, drive mN_read_data = all ones, assert mN_acknowledge, go HOLD.
REQ-026 Requester changing address/data while granted SHALL have no effect on bridge outputs (latched values held).
REQ-027 Requester withdrawing its request in ACTIVE before acknowledge SHALL be ignored; transaction completes normally.
REQ-028 mN_read_data SHALL hold its last value until the next read completion for that requester.

Reset
REQ-029 On reset assertion, immediately: state IDLE, grant=0, all bridge_uart_* outputs 0, mN_acknowledge=0, mN_read_data=0, timeout_error=0, counter=0, round-robin pointer=0.
REQ-030 Reset asserted mid-transaction SHALL abandon it with no acknowledge delivered; first grant after release follows REQ-019.

Verification
REQ-031 m0 read addr 0x00, bridge acks with data 0x168 -> grant=01, bridge_uart_read=1 addr 0x00, m0_read_data=0x168, m0_acknowledge high until m0_read drops, grant=00 after bridge ack drops.
REQ-032 m0 write and m1 read asserted same cycle after reset -> m0 served first, then m1; next simultaneous request -> m0 served first again only if m1 was last.
REQ-033 m1 read, bridge never acks, TIMEOUT_CYCLES=16 -> timeout_error pulse 16 cycles after ACTIVE entry, m1_read_data=0xFFFFFFFF, m1_acknowledge=1, bridge_uart_read=0.
REQ-034 m0 read with m0_address changed 0x05->0x3F while granted -> bridge_uart_address stays 0x05.
REQ-035 Reset asserted in HOLD -> all outputs 0 asynchronously; after release, pending m1 alone granted normally.
REQ-036 Back-to-back reads of bytes 0x67, 0x75, 0x69, 0x0A by m0 -> four complete handshakes, read_data sequence matches, no overlap of bridge requests.
